// File: rtl/victim_cache_pkg.sv
// Shared types for the victim cache and its writeback FIFO.
// Optional statistics counters are enabled with VICTIM_CACHE_STATS_EN.
package victim_cache_pkg;
    localparam int VC_LINES_DEF = 4;
    localparam int BLK_OFS_DEF  = 3;

    typedef logic [31:0] ADDR;
    typedef logic [63:0] MEM_BLOCK;

    typedef struct packed {
        logic     valid;
        MEM_BLOCK cache_line;
    } CACHE_DATA;

    // tag holds the block address (addr >> offset bits) so any offset width fits
    typedef struct packed {
        logic     valid;
        logic     dirty;
        ADDR      tag;
        MEM_BLOCK line;
    } VC_ENTRY;

    typedef struct packed {
        ADDR      addr;
        MEM_BLOCK data;
    } VC_WB_REQ;

    function automatic ADDR tag_of(ADDR a, int unsigned ofs);
        return a >> ofs;
    endfunction
endpackage

// File: rtl/victim_cache_wb_fifo.sv
// Two-deep in-order writeback FIFO: up to two pushes per edge (req[0] first),
// valid/ready pop, occupancy exposed as count.
module vc_wb_fifo
    import victim_cache_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          push,
    input  VC_WB_REQ [1:0]      req,
    output logic                valid,
    input  logic                ready,
    output VC_WB_REQ            head,
    output logic [1:0]          count
);
    VC_WB_REQ mem [2];
    logic     rd, wr;
    logic     pop;

    assign valid = (count != 2'd0);
    assign head  = mem[rd];
    assign pop   = valid && ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd    <= 1'b0;
            wr    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (pop) rd <= ~rd;
            wr    <= wr ^ (push[0] ^ push[1]);
            count <= count + 2'(push[0]) + 2'(push[1]) - 2'(pop);
        end
    end

    // storage needs no reset; valid gates the head
    always_ff @(posedge clock) begin
        case (push)
            2'b01: mem[wr] <= req[0];
            2'b10: mem[wr] <= req[1];
            2'b11: begin
                mem[wr]  <= req[0];
                mem[~wr] <= req[1];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/victim_cache.sv
// Fully-associative victim cache shared by icache and dcache with promote-on-hit
// and a dirty writeback drain. VICTIM_CACHE_STATS_EN adds hit/insert/writeback counters.
module victim_cache
    import victim_cache_pkg::*;
#(
    parameter int VC_LINES     = VC_LINES_DEF,
    parameter int BLK_OFS_BITS = BLK_OFS_DEF
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      ic_evict_valid,
    input  ADDR       ic_evict_addr,
    input  MEM_BLOCK  ic_evict_data,
    input  logic      dc_evict_valid,
    input  ADDR       dc_evict_addr,
    input  MEM_BLOCK  dc_evict_data,
    input  logic      dc_evict_dirty,
    output logic      evict_ready,
    input  logic      ic_lookup_valid,
    input  ADDR       ic_lookup_addr,
    output CACHE_DATA ic_lookup_out,
    input  logic      dc_lookup_valid,
    input  ADDR       dc_lookup_addr,
    output CACHE_DATA dc_lookup_out,
    output logic      dc_lookup_dirty,
`ifdef VICTIM_CACHE_STATS_EN
    output logic [31:0] stat_hits,
    output logic [31:0] stat_inserts,
    output logic [31:0] stat_writebacks,
`endif
    output logic      wb_valid,
    output ADDR       wb_addr,
    output MEM_BLOCK  wb_data,
    input  logic      wb_ready
);
    localparam int IW = $clog2(VC_LINES);

    VC_ENTRY ents [VC_LINES];
    VC_ENTRY nxt  [VC_LINES];
    logic [IW-1:0] repl_ptr, ptr_n, idx;
    logic [VC_LINES-1:0] ic_hit_vec, dc_hit_vec, freed;
    logic found, upd;
    logic ic_acc, dc_acc, ic_fwd_ic, ic_fwd_dc, dc_fwd_ic, dc_fwd_dc;
    ADDR  ic_lk_tag, dc_lk_tag;
    ADDR  ev_tag [2];
    MEM_BLOCK ev_data [2];
    logic [1:0] ev_dirty, ins, push;
    MEM_BLOCK ic_ent_line, dc_ent_line;
    logic dc_ent_dirty;
    VC_WB_REQ [1:0] wb_req;
    VC_WB_REQ wb_head;
    logic [1:0] wb_count;

    assign evict_ready = (wb_count == 2'd0);
    assign ic_acc      = ic_evict_valid && evict_ready;
    assign dc_acc      = dc_evict_valid && evict_ready;
    assign ic_lk_tag   = tag_of(ic_lookup_addr, BLK_OFS_BITS);
    assign dc_lk_tag   = tag_of(dc_lookup_addr, BLK_OFS_BITS);
    assign ev_tag[0]   = tag_of(ic_evict_addr, BLK_OFS_BITS);
    assign ev_tag[1]   = tag_of(dc_evict_addr, BLK_OFS_BITS);
    assign ev_data[0]  = ic_evict_data;
    assign ev_data[1]  = dc_evict_data;
    assign ev_dirty    = {dc_evict_dirty, 1'b0};

    // Forwarding: <probe>_fwd_<evict port>; a forwarded evict is handed over, not stored
    assign ic_fwd_ic = ic_lookup_valid && ic_acc && (ev_tag[0] == ic_lk_tag);
    assign ic_fwd_dc = ic_lookup_valid && dc_acc && (ev_tag[1] == ic_lk_tag);
    assign dc_fwd_ic = dc_lookup_valid && ic_acc && (ev_tag[0] == dc_lk_tag);
    assign dc_fwd_dc = dc_lookup_valid && dc_acc && (ev_tag[1] == dc_lk_tag);
    assign ins[0]    = ic_acc && !ic_fwd_ic && !dc_fwd_ic;
    assign ins[1]    = dc_acc && !ic_fwd_dc && !dc_fwd_dc;

    // Valid tags are unique, so the hit vectors are one-hot and OR into the data mux
    always_comb begin
        ic_ent_line  = '0;
        dc_ent_line  = '0;
        dc_ent_dirty = 1'b0;
        for (int i = 0; i < VC_LINES; i++) begin
            ic_hit_vec[i] = ic_lookup_valid && ents[i].valid && (ents[i].tag == ic_lk_tag);
            dc_hit_vec[i] = dc_lookup_valid && ents[i].valid && (ents[i].tag == dc_lk_tag);
            if (ic_hit_vec[i]) ic_ent_line |= ents[i].line;
            if (dc_hit_vec[i]) begin
                dc_ent_line  |= ents[i].line;
                dc_ent_dirty |= ents[i].dirty;
            end
        end
        ic_lookup_out.valid      = (|ic_hit_vec) || ic_fwd_ic || ic_fwd_dc;
        ic_lookup_out.cache_line = ic_fwd_dc ? dc_evict_data : (ic_fwd_ic ? ic_evict_data : ic_ent_line);
        dc_lookup_out.valid      = (|dc_hit_vec) || dc_fwd_ic || dc_fwd_dc;
        dc_lookup_out.cache_line = dc_fwd_dc ? dc_evict_data : (dc_fwd_ic ? ic_evict_data : dc_ent_line);
        dc_lookup_dirty          = (dc_fwd_dc && dc_evict_dirty) || dc_ent_dirty;
    end

    // Promote first, then place ic then dc on the updated view so dc sees ic's placement
    always_comb begin
        nxt    = ents;
        ptr_n  = repl_ptr;
        freed  = '0;
        push   = '0;
        wb_req = '0;
        found  = 1'b0;
        upd    = 1'b0;
        idx    = '0;
        for (int i = 0; i < VC_LINES; i++) begin
            if (ic_hit_vec[i] || dc_hit_vec[i]) begin
                nxt[i].valid = 1'b0;
                nxt[i].dirty = 1'b0;
                freed[i]     = 1'b1;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (ins[k]) begin
                found = 1'b0;
                upd   = 1'b0;
                idx   = '0;
                for (int i = 0; i < VC_LINES; i++) begin
                    if (!found && nxt[i].valid && (nxt[i].tag == ev_tag[k])) begin
                        found = 1'b1;
                        upd   = 1'b1;
                        idx   = IW'(i);
                    end
                end
                for (int i = 0; i < VC_LINES; i++) begin
                    if (!found && !nxt[i].valid && !freed[i]) begin
                        found = 1'b1;
                        idx   = IW'(i);
                    end
                end
                if (!found) begin
                    idx   = ptr_n;
                    ptr_n = ptr_n + 1'b1;
                    if (nxt[idx].valid && nxt[idx].dirty) begin
                        push[k]        = 1'b1;
                        wb_req[k].addr = nxt[idx].tag << BLK_OFS_BITS;
                        wb_req[k].data = nxt[idx].line;
                    end
                end
                nxt[idx].dirty = (upd && nxt[idx].dirty) || ev_dirty[k];
                nxt[idx].valid = 1'b1;
                nxt[idx].tag   = ev_tag[k];
                nxt[idx].line  = ev_data[k];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            repl_ptr <= '0;
            for (int i = 0; i < VC_LINES; i++) ents[i] <= '0;
        end else begin
            repl_ptr <= ptr_n;
            ents     <= nxt;
        end
    end

    vc_wb_fifo u_wb_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .req   (wb_req),
        .valid (wb_valid),
        .ready (wb_ready),
        .head  (wb_head),
        .count (wb_count)
    );

    assign wb_addr = wb_head.addr;
    assign wb_data = wb_head.data;

`ifdef VICTIM_CACHE_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_hits       <= '0;
            stat_inserts    <= '0;
            stat_writebacks <= '0;
        end else begin
            stat_hits       <= stat_hits + 32'(ic_lookup_out.valid) + 32'(dc_lookup_out.valid);
            stat_inserts    <= stat_inserts + 32'(ins[0]) + 32'(ins[1]);
            stat_writebacks <= stat_writebacks + 32'(wb_valid && wb_ready);
        end
    end
`endif
endmodule

// File: tb/tb_victim_cache.sv
// Self-checking bench for victim_cache: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_victim_cache;
    import victim_cache_pkg::*;

    logic      clock, reset;
    logic      ic_evict_valid, dc_evict_valid, dc_evict_dirty, evict_ready;
    ADDR       ic_evict_addr, dc_evict_addr;
    MEM_BLOCK  ic_evict_data, dc_evict_data;
    logic      ic_lookup_valid, dc_lookup_valid, dc_lookup_dirty;
    ADDR       ic_lookup_addr, dc_lookup_addr;
    CACHE_DATA ic_lookup_out, dc_lookup_out;
    logic      wb_valid, wb_ready;
    ADDR       wb_addr;
    MEM_BLOCK  wb_data;
`ifdef VICTIM_CACHE_STATS_EN
    logic [31:0] stat_hits, stat_inserts, stat_writebacks;
`endif

    victim_cache dut (
        .clock(clock), .reset(reset),
        .ic_evict_valid(ic_evict_valid), .ic_evict_addr(ic_evict_addr), .ic_evict_data(ic_evict_data),
        .dc_evict_valid(dc_evict_valid), .dc_evict_addr(dc_evict_addr), .dc_evict_data(dc_evict_data),
        .dc_evict_dirty(dc_evict_dirty), .evict_ready(evict_ready),
        .ic_lookup_valid(ic_lookup_valid), .ic_lookup_addr(ic_lookup_addr), .ic_lookup_out(ic_lookup_out),
        .dc_lookup_valid(dc_lookup_valid), .dc_lookup_addr(dc_lookup_addr), .dc_lookup_out(dc_lookup_out),
        .dc_lookup_dirty(dc_lookup_dirty),
`ifdef VICTIM_CACHE_STATS_EN
        .stat_hits(stat_hits), .stat_inserts(stat_inserts), .stat_writebacks(stat_writebacks),
`endif
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Behavioural model: 4 entries, round-robin pointer, writeback queue
    typedef struct { logic [31:0] a; logic [63:0] d; } wb_t;
    logic        m_valid [4];
    logic        m_dirty [4];
    logic [31:0] m_tag   [4];
    logic [63:0] m_line  [4];
    logic        m_freed [4];
    int          m_ptr;
    wb_t         wbq [$];
    logic        ic_acc_last, dc_acc_last;

    function automatic int find(input logic [31:0] t);
        for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == t) return i;
        return -1;
    endfunction

    function automatic void m_insert(input logic [31:0] t, input logic [63:0] d, input logic dirty);
        int j;
        wb_t w;
        j = find(t);
        if (j >= 0) begin
            m_dirty[j] = m_dirty[j] | dirty;
            m_line[j]  = d;
            return;
        end
        for (int i = 0; i < 4; i++) if (j < 0 && !m_valid[i] && !m_freed[i]) j = i;
        if (j < 0) begin
            j = m_ptr;
            m_ptr = (m_ptr + 1) % 4;
            if (m_valid[j] && m_dirty[j]) begin
                w.a = m_tag[j] << 3;
                w.d = m_line[j];
                wbq.push_back(w);
            end
        end
        m_valid[j] = 1'b1; m_dirty[j] = dirty; m_tag[j] = t; m_line[j] = d;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0; m_line[i] = 0; m_freed[i] = 0;
        end
        m_ptr = 0;
        wbq.delete();
    endfunction

    // Compare at negedge, advance the model, then step to just after the next posedge
    task automatic cyc();
        logic rdy, ia, da, ih, dh, dd;
        logic [63:0] il, dl;
        logic [31:0] it, dt, et, edt;
        int j;
        @(negedge clock);
        rdy = (wbq.size() == 0);
        ia  = ic_evict_valid && rdy;
        da  = dc_evict_valid && rdy;
        et  = ic_evict_addr >> 3;  edt = dc_evict_addr >> 3;
        it  = ic_lookup_addr >> 3; dt  = dc_lookup_addr >> 3;
        ih = 0; il = 0; dh = 0; dl = 0; dd = 0;
        if (ic_lookup_valid) begin
            j = find(it);
            if (j >= 0) begin ih = 1; il = m_line[j]; end
            if (ia && et == it)  begin ih = 1; il = ic_evict_data; end
            if (da && edt == it) begin ih = 1; il = dc_evict_data; end
        end
        if (dc_lookup_valid) begin
            j = find(dt);
            if (j >= 0) begin dh = 1; dl = m_line[j]; dd = m_dirty[j]; end
            if (ia && et == dt)  begin dh = 1; dl = ic_evict_data; end
            if (da && edt == dt) begin dh = 1; dl = dc_evict_data; dd = dd | dc_evict_dirty; end
        end
        chk("evict_ready", evict_ready, rdy);
        chk("ic_hit", ic_lookup_out.valid, ih);
        if (ih) chk("ic_line", ic_lookup_out.cache_line, il);
        chk("dc_hit", dc_lookup_out.valid, dh);
        if (dh) begin
            chk("dc_line", dc_lookup_out.cache_line, dl);
            chk("dc_dirty", dc_lookup_dirty, dd);
        end
        chk("wb_valid", wb_valid, wbq.size() > 0);
        if (wbq.size() > 0) begin
            chk("wb_addr", wb_addr, wbq[0].a);
            chk("wb_data", wb_data, wbq[0].d);
        end
        if (wbq.size() > 0 && wb_ready) void'(wbq.pop_front());
        for (int i = 0; i < 4; i++) begin
            m_freed[i] = 0;
            if (m_valid[i] && ((ic_lookup_valid && m_tag[i] == it) || (dc_lookup_valid && m_tag[i] == dt))) begin
                m_valid[i] = 0; m_dirty[i] = 0; m_freed[i] = 1;
            end
        end
        if (ia && !(ic_lookup_valid && et == it) && !(dc_lookup_valid && et == dt)) m_insert(et, ic_evict_data, 1'b0);
        if (da && !(ic_lookup_valid && edt == it) && !(dc_lookup_valid && edt == dt)) m_insert(edt, dc_evict_data, dc_evict_dirty);
        ic_acc_last = ia;
        dc_acc_last = da;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        ic_evict_valid = 0; ic_evict_addr = 0; ic_evict_data = 0;
        dc_evict_valid = 0; dc_evict_addr = 0; dc_evict_data = 0; dc_evict_dirty = 0;
        ic_lookup_valid = 0; ic_lookup_addr = 0; dc_lookup_valid = 0; dc_lookup_addr = 0;
        wb_ready = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        m_clear();
        #3;
        chk("rst_evict_ready", evict_ready, 1);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_ic_valid", ic_lookup_out.valid, 0);
        chk("rst_dc_valid", dc_lookup_out.valid, 0);
        @(negedge clock);
        reset = 0;
        @(posedge clock);
        #1;
    endtask

    task automatic fill_dc(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            dc_evict_valid = 1; dc_evict_dirty = 1;
            dc_evict_addr  = base + 32'(i) * 32'h100;
            dc_evict_data  = {32'hD0D00000 + 32'(i), base};
            cyc();
        end
        dc_evict_valid = 0; dc_evict_dirty = 0;
    endtask

    function automatic logic [31:0] rand_addr();
        return (32'h8000 + ($urandom % 8) * 32'h40) | ($urandom % 8);
    endfunction

    initial begin
        reset = 1;
        clear_inputs();
        ic_acc_last = 0; dc_acc_last = 0;

        // 1: insert then promote
        do_reset();
        ic_evict_valid = 1; ic_evict_addr = 32'h1000; ic_evict_data = 64'hA1A1A1A1_00001000;
        cyc();
        ic_evict_valid = 0; ic_lookup_valid = 1; ic_lookup_addr = 32'h1000;
        #2;
        chk("t1_hit", ic_lookup_out.valid, 1);
        chk("t1_line", ic_lookup_out.cache_line, 64'hA1A1A1A1_00001000);
        cyc();
        #2;
        chk("t1_promoted", ic_lookup_out.valid, 0);
        cyc();
        ic_lookup_valid = 0;

        // 2: clean replacement, pointer advance
        do_reset();
        for (int i = 0; i < 6; i++) begin
            ic_evict_valid = 1;
            ic_evict_addr  = (i < 4) ? 32'h1100 + 32'(i) * 32'h100 : 32'h2000 + 32'(i - 4) * 32'h100;
            ic_evict_data  = {32'hC0C00000 + 32'(i), 32'h0};
            cyc();
        end
        ic_evict_valid = 0;
        ic_lookup_valid = 1; ic_lookup_addr = 32'h1200;
        dc_lookup_valid = 1; dc_lookup_addr = 32'h1300;
        #2;
        chk("t2_ent1_replaced", ic_lookup_out.valid, 0);
        chk("t2_ent2_kept", dc_lookup_out.valid, 1);
        chk("t2_ent2_line", dc_lookup_out.cache_line, 64'hC0C00002_00000000);
        chk("t2_no_wb", wb_valid, 0);
        cyc();
        ic_lookup_valid = 0; dc_lookup_valid = 0;

        // 3: dual dirty displacement and in-order drain
        do_reset();
        fill_dc(32'h5000, 4);
        ic_evict_valid = 1; ic_evict_addr = 32'h6000; ic_evict_data = 64'h6;
        dc_evict_valid = 1; dc_evict_addr = 32'h6100; dc_evict_data = 64'h61; dc_evict_dirty = 1;
        cyc();
        ic_evict_valid = 0; dc_evict_valid = 0; dc_evict_dirty = 0;
        chk("t3_not_ready", evict_ready, 0);
        chk("t3_wb0_addr", wb_addr, 32'h5000);
        chk("t3_wb0_data", wb_data, 64'hD0D00000_00005000);
        wb_ready = 1;
        cyc();
        chk("t3_wb1_addr", wb_addr, 32'h5100);
        chk("t3_still_not_ready", evict_ready, 0);
        cyc();
        chk("t3_drained", wb_valid, 0);
        chk("t3_ready", evict_ready, 1);
        wb_ready = 0;

        // 4: forwarding a same-cycle dirty evict
        do_reset();
        dc_evict_valid = 1; dc_evict_addr = 32'h3000; dc_evict_data = 64'h3333; dc_evict_dirty = 1;
        dc_lookup_valid = 1; dc_lookup_addr = 32'h3000;
        #2;
        chk("t4_fwd_hit", dc_lookup_out.valid, 1);
        chk("t4_fwd_line", dc_lookup_out.cache_line, 64'h3333);
        chk("t4_fwd_dirty", dc_lookup_dirty, 1);
        cyc();
        dc_evict_valid = 0; dc_evict_dirty = 0;
        #2;
        chk("t4_not_alloc", dc_lookup_out.valid, 0);
        cyc();
        dc_lookup_valid = 0;

        // 5: dual probe of one dirty entry
        do_reset();
        dc_evict_valid = 1; dc_evict_addr = 32'h4000; dc_evict_data = 64'h4444; dc_evict_dirty = 1;
        cyc();
        dc_evict_valid = 0; dc_evict_dirty = 0;
        ic_lookup_valid = 1; ic_lookup_addr = 32'h4000;
        dc_lookup_valid = 1; dc_lookup_addr = 32'h4000;
        #2;
        chk("t5_ic_hit", ic_lookup_out.valid, 1);
        chk("t5_dc_hit", dc_lookup_out.valid, 1);
        chk("t5_ic_line", ic_lookup_out.cache_line, 64'h4444);
        chk("t5_dc_dirty", dc_lookup_dirty, 1);
        cyc();
        #2;
        chk("t5_ic_gone", ic_lookup_out.valid, 0);
        chk("t5_dc_gone", dc_lookup_out.valid, 0);
        cyc();
        ic_lookup_valid = 0; dc_lookup_valid = 0;

        // 6: asynchronous reset while a writeback is pending
        do_reset();
        fill_dc(32'h7000, 5);
        chk("t6_wb_pending", wb_valid, 1);
        #1;
        reset = 1;
        #1;
        chk("t6_wb_dropped", wb_valid, 0);
        chk("t6_ready", evict_ready, 1);
        ic_lookup_valid = 1; ic_lookup_addr = 32'h7100;
        dc_lookup_valid = 1; dc_lookup_addr = 32'h7200;
        #1;
        chk("t6_ic_miss", ic_lookup_out.valid, 0);
        chk("t6_dc_miss", dc_lookup_out.valid, 0);
        do_reset();

        // Random traffic; evicts are held until accepted
        ic_acc_last = 0; dc_acc_last = 0;
        for (int n = 0; n < 3000; n++) begin
            if (ic_acc_last) ic_evict_valid = 0;
            if (dc_acc_last) dc_evict_valid = 0;
            if (!ic_evict_valid && ($urandom % 3 == 0)) begin
                ic_evict_valid = 1; ic_evict_addr = rand_addr();
                ic_evict_data  = {$urandom, $urandom};
            end
            if (!dc_evict_valid && ($urandom % 3 == 0)) begin
                dc_evict_valid = 1; dc_evict_addr = rand_addr();
                dc_evict_data  = {$urandom, $urandom}; dc_evict_dirty = 1'($urandom);
            end
            ic_lookup_valid = ($urandom % 5 < 2); ic_lookup_addr = rand_addr();
            dc_lookup_valid = ($urandom % 5 < 2); dc_lookup_addr = rand_addr();
            wb_ready = 1'($urandom);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
